// File: rtl/cpi_pkg.sv
// Shared CPI types: pad bundle, capture FSM states, slice-window config.
package cpi_pkg;

    localparam int CPI_DATA_W  = 10;
    localparam int CPI_COORD_W = 16;

    typedef struct packed {
        logic pclk_i;
        logic hsync_i;
        logic vsync_i;
        logic data0_i;
        logic data1_i;
        logic data2_i;
        logic data3_i;
        logic data4_i;
        logic data5_i;
        logic data6_i;
        logic data7_i;
        logic data8_i;
        logic data9_i;
    } pad_to_cpi_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        SKIP    = 2'd2,
        CAPTURE = 2'd3
    } cpi_state_e;

    typedef struct packed {
        logic                   en;
        logic [CPI_COORD_W-1:0] llx;
        logic [CPI_COORD_W-1:0] lly;
        logic [CPI_COORD_W-1:0] urx;
        logic [CPI_COORD_W-1:0] ury;
    } cpi_slice_cfg_t;

    // Gather the individual data pins into a bus, data9 as MSB.
    function automatic logic [CPI_DATA_W-1:0] cpi_pack_data(input pad_to_cpi_t p);
        return {p.data9_i, p.data8_i, p.data7_i, p.data6_i, p.data5_i,
                p.data4_i, p.data3_i, p.data2_i, p.data1_i, p.data0_i};
    endfunction

endpackage

// File: rtl/cpi_sync_edge.sv
// Stage-1 capture of the CPI pins plus edge detection on hsync (fall)
// and vsync (rise) against a one-cycle delayed copy.
module cpi_sync_edge #(
    parameter int DATA_W = 10
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              hsync_i,
    input  logic              vsync_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic [DATA_W-1:0] data_o,
    output logic              hsync_fall_o,
    output logic              vsync_rise_o
);

    logic              hsync_q;
    logic              vsync_q;
    logic              hsync_dly_q;
    logic              vsync_dly_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            hsync_dly_q <= 1'b0;
            vsync_dly_q <= 1'b0;
            data_q      <= '0;
        end else begin
            hsync_q     <= hsync_i;
            vsync_q     <= vsync_i;
            hsync_dly_q <= hsync_q;
            vsync_dly_q <= vsync_q;
            data_q      <= data_i;
        end
    end

    assign hsync_o      = hsync_q;
    assign vsync_o      = vsync_q;
    assign data_o       = data_q;
    assign hsync_fall_o = hsync_dly_q & ~hsync_q;
    assign vsync_rise_o = vsync_q & ~vsync_dly_q;

endmodule

// File: rtl/cpi_frame_ctrl.sv
// CPI capture sequencer: frame/line tracking, frame decimation, slice window
// and a single-entry output register that reports overruns instead of stalling.
module cpi_frame_ctrl
    import cpi_pkg::*;
#(
    parameter int COORD_W = 16,
    parameter int DROP_W  = 6
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  pad_to_cpi_t           cpi_i,
    input  logic                  cfg_en_i,
    input  logic                  cfg_drop_en_i,
    input  logic [DROP_W-1:0]     cfg_drop_val_i,
    input  logic                  cfg_slice_en_i,
    input  logic [COORD_W-1:0]    cfg_llx_i,
    input  logic [COORD_W-1:0]    cfg_lly_i,
    input  logic [COORD_W-1:0]    cfg_urx_i,
    input  logic [COORD_W-1:0]    cfg_ury_i,
    output logic [CPI_DATA_W-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  frame_start_o,
    output logic                  frame_end_o,
    output logic                  overflow_o,
    output logic                  busy_o
);

    logic                  unused_pclk;
    logic [CPI_DATA_W-1:0] pin_data;
    logic                  hsync_s;
    logic                  vsync_s;
    logic [CPI_DATA_W-1:0] data_s;
    logic                  hsync_fall;
    logic                  vsync_rise;

    assign unused_pclk = cpi_i.pclk_i;
    assign pin_data    = cpi_pack_data(cpi_i);

    cpi_sync_edge #(
        .DATA_W (CPI_DATA_W)
    ) u_sync (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .hsync_i      (cpi_i.hsync_i),
        .vsync_i      (cpi_i.vsync_i),
        .data_i       (pin_data),
        .hsync_o      (hsync_s),
        .vsync_o      (vsync_s),
        .data_o       (data_s),
        .hsync_fall_o (hsync_fall),
        .vsync_rise_o (vsync_rise)
    );

    cpi_state_e            state_q, state_d;
    logic [COORD_W-1:0]    col_q, col_d;
    logic [COORD_W-1:0]    row_q, row_d;
    logic [DROP_W-1:0]     drop_cnt_q, drop_cnt_d;
    logic [DROP_W-1:0]     drop_next;
    logic                  slice_en_q, slice_en_d;
    logic [COORD_W-1:0]    llx_q, llx_d;
    logic [COORD_W-1:0]    lly_q, lly_d;
    logic [COORD_W-1:0]    urx_q, urx_d;
    logic [COORD_W-1:0]    ury_q, ury_d;
    logic [CPI_DATA_W-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  frame_start_q, frame_start_d;
    logic                  frame_end_q, frame_end_d;
    logic                  overflow_q, overflow_d;
    logic                  busy_q, busy_d;
    logic                  in_window;
    logic                  sample_sel;
    logic                  load;

    // The drop test looks at the count before this frame; the count then advances.
    assign drop_next = (cfg_drop_en_i && (drop_cnt_q < cfg_drop_val_i))
                     ? drop_cnt_q + 1'b1 : '0;

    assign in_window = (llx_q <= col_q) && (col_q <= urx_q) &&
                       (lly_q <= row_q) && (row_q <= ury_q);

    assign sample_sel = (state_q == CAPTURE) && hsync_s && !vsync_rise &&
                        (!slice_en_q || in_window);

    assign load = sample_sel && (!valid_q || ready_i);

    always_comb begin
        state_d       = state_q;
        drop_cnt_d    = drop_cnt_q;
        col_d         = col_q;
        row_d         = row_q;
        slice_en_d    = slice_en_q;
        llx_d         = llx_q;
        lly_d         = lly_q;
        urx_d         = urx_q;
        ury_d         = ury_q;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;

        if (vsync_rise) begin
            col_d      = '0;
            row_d      = '0;
            slice_en_d = cfg_slice_en_i;
            llx_d      = cfg_llx_i;
            lly_d      = cfg_lly_i;
            urx_d      = cfg_urx_i;
            ury_d      = cfg_ury_i;
        end else if (hsync_fall) begin
            col_d = '0;
            if (!(&row_q)) row_d = row_q + 1'b1;
        end else if (hsync_s && !(&col_q)) begin
            col_d = col_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                drop_cnt_d = '0;
                if (cfg_en_i) state_d = ARMED;
            end
            ARMED, SKIP: begin
                if (!cfg_en_i) begin
                    state_d    = IDLE;
                    drop_cnt_d = '0;
                end else if (vsync_rise) begin
                    state_d       = (drop_cnt_q == '0) ? CAPTURE : SKIP;
                    frame_start_d = (drop_cnt_q == '0);
                    drop_cnt_d    = drop_next;
                end
            end
            CAPTURE: begin
                // A frame in flight always completes; disable only acts at its end.
                if (vsync_rise) begin
                    frame_end_d = 1'b1;
                    if (!cfg_en_i) begin
                        state_d    = IDLE;
                        drop_cnt_d = '0;
                    end else begin
                        state_d       = (drop_cnt_q == '0) ? CAPTURE : SKIP;
                        frame_start_d = (drop_cnt_q == '0);
                        drop_cnt_d    = drop_next;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        data_d     = load ? data_s : data_q;
        valid_d    = load ? 1'b1 : ((valid_q && ready_i) ? 1'b0 : valid_q);
        overflow_d = sample_sel && !load;
        busy_d     = (state_d == CAPTURE);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= IDLE;
            drop_cnt_q    <= '0;
            col_q         <= '0;
            row_q         <= '0;
            slice_en_q    <= 1'b0;
            llx_q         <= '0;
            lly_q         <= '0;
            urx_q         <= '0;
            ury_q         <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            overflow_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            drop_cnt_q    <= drop_cnt_d;
            col_q         <= col_d;
            row_q         <= row_d;
            slice_en_q    <= slice_en_d;
            llx_q         <= llx_d;
            lly_q         <= lly_d;
            urx_q         <= urx_d;
            ury_q         <= ury_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            overflow_q    <= overflow_d;
            busy_q        <= busy_d;
        end
    end

    assign data_o        = data_q;
    assign valid_o       = valid_q;
    assign frame_start_o = frame_start_q;
    assign frame_end_o   = frame_end_q;
    assign overflow_o    = overflow_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_cpi_frame_ctrl.sv
// Bench for cpi_frame_ctrl: table of frame scenarios, hand-written corner
// sequences and randomized rounds checked against a frame-level model.
module tb_cpi_frame_ctrl;
    import cpi_pkg::*;

    localparam int CW = 16;
    localparam int DW = 6;

    logic           clk = 1'b0;
    logic           rstn;
    pad_to_cpi_t    cpi;
    logic           cfg_en, cfg_drop_en, cfg_slice_en;
    logic [DW-1:0]  cfg_drop_val;
    logic [CW-1:0]  llx, lly, urx, ury;
    logic [9:0]     data_o;
    logic           valid_o, ready, fs_o, fe_o, ovf_o, busy_o;

    always #5 clk = ~clk;

    cpi_frame_ctrl #(.COORD_W(CW), .DROP_W(DW)) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .cpi_i          (cpi),
        .cfg_en_i       (cfg_en),
        .cfg_drop_en_i  (cfg_drop_en),
        .cfg_drop_val_i (cfg_drop_val),
        .cfg_slice_en_i (cfg_slice_en),
        .cfg_llx_i      (llx),
        .cfg_lly_i      (lly),
        .cfg_urx_i      (urx),
        .cfg_ury_i      (ury),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .ready_i        (ready),
        .frame_start_o  (fs_o),
        .frame_end_o    (fe_o),
        .overflow_o     (ovf_o),
        .busy_o         (busy_o)
    );

    typedef struct {
        int lines; int cols;
        bit slice; int x0; int y0; int x1; int y1;
        bit drop_en; int drop_val; int frames;
        int exp_beats; int exp_fs;
    } vec_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_fs, n_fe, n_ovf;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    bit         rand_ready = 0;
    logic [9:0] pix;

    always @(negedge clk) begin
        if (valid_o && ready) got_q.push_back(data_o);
        if (fs_o)  n_fs++;
        if (fe_o)  n_fe++;
        if (ovf_o) n_ovf++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic clear();
        got_q.delete();
        exp_q.delete();
        n_fs = 0; n_fe = 0; n_ovf = 0;
        pix = 10'h000;
    endtask

    task automatic drive(input logic h, input logic v, input logic [9:0] d);
        cpi.pclk_i  = 1'b0;
        cpi.hsync_i = h;
        cpi.vsync_i = v;
        {cpi.data9_i, cpi.data8_i, cpi.data7_i, cpi.data6_i, cpi.data5_i,
         cpi.data4_i, cpi.data3_i, cpi.data2_i, cpi.data1_i, cpi.data0_i} = d;
        if (rand_ready) ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    // Model: a captured frame yields every sample inside the window, in raster order.
    task automatic send_frame(input int lines, input int cols, input bit cap, input int dis_after);
        drive(0, 1, 0); drive(0, 1, 0); drive(0, 0, 0); drive(0, 0, 0);
        check("busy at frame start", int'(busy_o), int'(cap));
        for (int r = 0; r < lines; r++) begin
            for (int c = 0; c < cols; c++) begin
                if (cap && (!cfg_slice_en || (c >= int'(llx) && c <= int'(urx) &&
                                              r >= int'(lly) && r <= int'(ury))))
                    exp_q.push_back(pix);
                drive(1, 0, pix);
                pix = pix + 10'd1;
            end
            if (r == dis_after) cfg_en = 1'b0;
            drive(0, 0, 0); drive(0, 0, 0);
        end
    endtask

    task automatic close_run();
        cfg_en = 1'b0;
        drive(0, 0, 0); drive(0, 0, 0);
        drive(0, 1, 0); drive(0, 0, 0);
        rand_ready = 0;
        ready = 1'b1;
        repeat (6) drive(0, 0, 0);
    endtask

    task automatic check_beats(input string tag);
        check({tag, " beat count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, " beat data"}, int'(got_q[i]), int'(exp_q[i]));
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{3, 4, 0, 0, 0, 0, 0, 0, 0, 1, 12, 1};
        vecs[1] = '{3, 4, 1, 1, 1, 2, 1, 0, 0, 1,  2, 1};
        vecs[2] = '{2, 3, 0, 0, 0, 0, 0, 1, 2, 7, 18, 3};
        vecs[3] = '{3, 4, 1, 2, 0, 1, 2, 0, 0, 1,  0, 1};
        vecs[4] = '{2, 5, 1, 4, 1, 9, 9, 0, 0, 1,  1, 1};
        vecs[5] = '{2, 2, 0, 0, 0, 0, 0, 1, 0, 3, 12, 3};
        vecs[6] = '{1, 6, 1, 0, 0, 0, 0, 0, 0, 1,  1, 1};
        vecs[7] = '{3, 4, 1, 0, 2, 3, 1, 0, 0, 1,  0, 1};

        rstn = 1'b0;
        cfg_en = 0; cfg_drop_en = 0; cfg_drop_val = '0; cfg_slice_en = 0;
        llx = '0; lly = '0; urx = '0; ury = '0; ready = 1'b1;
        clear();
        repeat (3) drive(0, 0, 0);
        check("reset outputs", int'({data_o, valid_o, fs_o, fe_o, ovf_o, busy_o}), 0);
        rstn = 1'b1;
        drive(0, 0, 0);

        // Table-driven frame scenarios.
        for (int v = 0; v < 8; v++) begin
            clear();
            cfg_slice_en = vecs[v].slice;
            llx = CW'(vecs[v].x0); lly = CW'(vecs[v].y0);
            urx = CW'(vecs[v].x1); ury = CW'(vecs[v].y1);
            cfg_drop_en = vecs[v].drop_en;
            cfg_drop_val = DW'(vecs[v].drop_val);
            cfg_en = 1'b1;
            repeat (3) drive(0, 0, 0);
            for (int k = 0; k < vecs[v].frames; k++)
                send_frame(vecs[v].lines, vecs[v].cols,
                           !vecs[v].drop_en || (k % (vecs[v].drop_val + 1)) == 0, -1);
            close_run();
            check("vec beats vs table", got_q.size(), vecs[v].exp_beats);
            check_beats("vec");
            check("vec frame_start", n_fs, vecs[v].exp_fs);
            check("vec frame_end", n_fe, vecs[v].exp_fs);
            check("vec idle busy", int'(busy_o), 0);
            $display("vec %0d: beats=%0d starts=%0d ends=%0d", v, got_q.size(), n_fs, n_fe);
        end

        // Frame-pulse latency, data latency and back-pressure.
        clear();
        cfg_slice_en = 0; cfg_drop_en = 0; cfg_en = 1'b1; ready = 1'b1;
        repeat (3) drive(0, 0, 0);
        drive(0, 1, 0);
        check("frame_start t+1", int'(fs_o), 0);
        drive(0, 0, 0);
        check("frame_start t+2", int'(fs_o), 1);
        drive(0, 0, 0);
        check("frame_start t+3", int'(fs_o), 0);
        ready = 1'b0;
        drive(1, 0, 10'h1A1);
        check("valid t+1", int'(valid_o), 0);
        drive(1, 0, 10'h1A2);
        check("valid t+2", int'(valid_o), 1);
        check("data t+2", int'(data_o), 'h1A1);
        drive(1, 0, 10'h1A3);
        drive(0, 0, 0); drive(0, 0, 0);
        check("bp held data", int'(data_o), 'h1A1);
        check("bp overflow count", n_ovf, 2);
        check("bp no beat yet", got_q.size(), 0);
        ready = 1'b1;
        drive(0, 0, 0); drive(0, 0, 0);
        exp_q.push_back(10'h1A1);
        check_beats("bp");
        check("bp valid cleared", int'(valid_o), 0);
        close_run();
        check("bp frame_end", n_fe, 1);
        $display("backpressure: beats=%0d overflows=%0d", got_q.size(), n_ovf);

        // Disable after line 1: frame completes, then nothing further.
        clear();
        cfg_en = 1'b1;
        repeat (3) drive(0, 0, 0);
        send_frame(3, 4, 1, 0);
        close_run();
        send_frame(2, 4, 0, -1);
        close_run();
        check_beats("disable");
        check("disable frame_start", n_fs, 1);
        check("disable frame_end", n_fe, 1);
        $display("disable: beats=%0d starts=%0d ends=%0d", got_q.size(), n_fs, n_fe);

        // vsync rise coincident with hsync: that sample is ignored, column restarts at 0.
        clear();
        cfg_slice_en = 1; llx = '0; urx = '0; lly = '0; ury = '0; cfg_en = 1'b1;
        repeat (3) drive(0, 0, 0);
        drive(1, 1, 10'h3AA);
        drive(1, 0, 10'h011); drive(1, 0, 10'h022); drive(1, 0, 10'h033);
        drive(0, 0, 0); drive(0, 0, 0);
        exp_q.push_back(10'h011);
        close_run();
        check_beats("vsync+hsync");
        $display("vsync+hsync: beats=%0d", got_q.size());

        // Asynchronous reset mid-line.
        clear();
        cfg_slice_en = 0; cfg_en = 1'b1;
        repeat (3) drive(0, 0, 0);
        drive(0, 1, 0); drive(0, 0, 0); drive(0, 0, 0);
        drive(1, 0, 10'h050); drive(1, 0, 10'h051); drive(1, 0, 10'h052);
        check("pre-reset valid", int'(valid_o), 1);
        #2 rstn = 1'b0;
        #1 check("async reset outputs", int'({data_o, valid_o, fs_o, fe_o, ovf_o, busy_o}), 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        clear();
        drive(1, 0, 10'h053); drive(1, 0, 10'h054); drive(0, 0, 0); drive(0, 0, 0);
        repeat (4) drive(1, 0, 10'h060);
        drive(0, 0, 0); drive(0, 0, 0);
        check("post-reset no beats", got_q.size(), 0);
        send_frame(2, 3, 1, -1);
        close_run();
        check_beats("post-reset");
        check("post-reset frame_start", n_fs, 1);
        $display("async reset: beats=%0d", got_q.size());

        // Randomized rounds with random ready: accepted beats are an in-order
        // subsequence of the selected samples, and accepted + overflowed = selected.
        for (int rnd = 0; rnd < 8; rnd++) begin
            int nfr, nl, nc, ncap, j;
            bit ok;
            clear();
            cfg_slice_en = 1'($urandom_range(0, 1));
            llx = CW'($urandom_range(0, 5)); urx = CW'($urandom_range(0, 5));
            lly = CW'($urandom_range(0, 3)); ury = CW'($urandom_range(0, 3));
            cfg_drop_en = 1'($urandom_range(0, 1));
            cfg_drop_val = DW'($urandom_range(0, 2));
            nfr = $urandom_range(2, 4);
            nl = $urandom_range(1, 4);
            nc = $urandom_range(1, 6);
            cfg_en = 1'b1;
            ready = 1'b1;
            repeat (3) drive(0, 0, 0);
            rand_ready = 1;
            ncap = 0;
            for (int k = 0; k < nfr; k++) begin
                bit cap;
                cap = !cfg_drop_en || (k % (int'(cfg_drop_val) + 1)) == 0;
                ncap += int'(cap);
                send_frame(nl, nc, cap, -1);
            end
            close_run();
            check("rand accepted+overflow", got_q.size() + n_ovf, exp_q.size());
            ok = 1; j = 0;
            foreach (got_q[i]) begin
                while (j < exp_q.size() && exp_q[j] != got_q[i]) j++;
                if (j >= exp_q.size()) ok = 0;
                else j++;
            end
            check("rand beat order", int'(ok), 1);
            check("rand frame_start", n_fs, ncap);
            check("rand frame_end", n_fe, ncap);
            $display("rand %0d: selected=%0d accepted=%0d overflow=%0d frames=%0d",
                     rnd, exp_q.size(), got_q.size(), n_ovf, ncap);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpi_frame_ctrl.md
# cpi_frame_ctrl

Capture sequencer for the camera parallel interface, running in the pixel-clock domain between the pad-side CPI bundle and the uDMA RX FIFO. Tracks frame and line boundaries from vsync/hsync, applies frame decimation and an optional rectangular slice window, and forwards selected samples over a valid/ready handshake. Overruns are reported, never stalled, because the sensor cannot be back-pressured.

## Interface
Parameters:
- `COORD_W`, 16: width of the row/column counters and slice coordinates.
- `DROP_W`, 6: width of the frame-drop ratio.

Ports:
- `clk_i` in 1: camera pixel clock; the block's only clock.
- `rstn_i` in 1: reset, asynchronous, active-low.
- `cpi_i` in `cpi_pkg::pad_to_cpi_t`: uses `hsync_i`, `vsync_i` and `data0_i`..`data9_i`; `pclk_i` is ignored.
- `cfg_en_i` in 1: capture enable.
- `cfg_drop_en_i` in 1: frame decimation enable.
- `cfg_drop_val_i` in DROP_W: number of frames to skip after each captured frame.
- `cfg_slice_en_i` in 1: window enable.
- `cfg_llx_i`, `cfg_lly_i`, `cfg_urx_i`, `cfg_ury_i` in COORD_W each: inclusive window corners (column, row).
- `data_o` out 10: sample; `data9_i` is the MSB.
- `valid_o` out 1: sample available.
- `ready_i` in 1: downstream accepts.
- `frame_start_o` out 1: one-cycle pulse when a captured frame begins.
- `frame_end_o` out 1: one-cycle pulse when a captured frame ends.
- `overflow_o` out 1: one-cycle pulse for each dropped sample.
- `busy_o` out 1: high while in the CAPTURE state.

## Operation
- **Stage 1.** Registers hsync, vsync and data, plus delayed copies of hsync and vsync for edge detection. All decisions below use stage 1.
- **Frame start.** A rising edge on vsync.
- **Line sample.** Any cycle with hsync high.
- **Column counter.** Reset to 0 on a vsync rising edge and on an hsync falling edge. Increments after each line sample. Saturates at all-ones.
- **Row counter.** Reset to 0 on a vsync rising edge. Increments on each hsync falling edge. Saturates at all-ones.
- **Config sampling.** All `cfg_*` values except `cfg_en_i` are latched on the vsync rising edge. Changes take effect at the next frame.
- **State machine.** States are IDLE, ARMED, SKIP and CAPTURE. Transitions:
  - IDLE → ARMED when `cfg_en_i`=1.
  - ARMED → CAPTURE on a vsync rise if drop counter = 0, otherwise ARMED → SKIP.
  - SKIP → CAPTURE or SKIP on each vsync rise, by the same test.
  - CAPTURE → CAPTURE or SKIP on a vsync rise while `cfg_en_i`=1. The same vsync rise also pulses `frame_end_o`.
  - CAPTURE → IDLE on a vsync rise while `cfg_en_i`=0, pulsing `frame_end_o`.
  - ARMED or SKIP → IDLE immediately when `cfg_en_i`=0.
  - Disabling therefore never truncates a frame already being captured.
- **Drop counter.**
  - Counts 0..`cfg_drop_val_i` on each vsync rise and wraps to 0.
  - When `cfg_drop_en_i`=0 it is held at 0.
  - Cleared in IDLE.
  - With a value of 2, frames 0, 3, 6, ... are captured.
- **frame_start_o.** Pulses on the vsync rise that enters or remains in CAPTURE.
- **Sample selection.** A line sample is selected when all of the following hold:
  - the state is CAPTURE;
  - it is not a vsync-rise cycle;
  - either `cfg_slice_en_i`=0, or llx ≤ col ≤ urx and lly ≤ row ≤ ury (unsigned comparison).
  - A window with llx > urx or lly > ury selects nothing.
- **Output register.**
  - A selected sample loads `data_o` and sets `valid_o`, provided `valid_o`=0 or `ready_i`=1 in that cycle.
  - Otherwise the new sample is discarded and `overflow_o` pulses. The held beat is unchanged.
  - `valid_o` clears on `valid_o && ready_i` when no new sample is loaded in the same cycle.
  - The pending beat survives a transition to IDLE.
- **Reset values.** All outputs are 0. State is IDLE, and all counters and stage registers are 0.

## Timing
- **Latency.** A pin sample at cycle t appears on `data_o`/`valid_o` at t+2 if selected. Throughput is one sample per cycle.
- **Frame pulses.** A vsync pin rise at t produces `frame_start_o` / `frame_end_o` at t+2.
- **Overflow.** `overflow_o` is asserted at t+2 for a sample at t.
- **Edge cases.**
  - A vsync rise together with hsync high: the sample is ignored, and counters reset.
  - Back-to-back hsync with no low gap is one line.
  - An asynchronous reset mid-frame returns the block to IDLE immediately. The next capture begins only at a full frame.

## Structure
- **Shared package additions to `cpi_pkg`:**
  - `cpi_state_e` (IDLE, ARMED, SKIP, CAPTURE);
  - `cpi_slice_cfg_t`, a packed struct of the four corners plus the enable;
  - constant `CPI_DATA_W` = 10.
- **Sub-module.** `cpi_sync_edge` provides the stage-1 register plus rise/fall detection for hsync and vsync.
- Counters, the state machine and the output register live in the top module.

## Test plan
- **Basic capture.** Enable, 4×3 frame (3 lines of 4 samples, data = 10'h000..10'h00B), `ready_i`=1 → 12 beats in order, `frame_start_o` once; `frame_end_o` at the next vsync rise.
- **Slice window.** Window llx=1, urx=2, lly=1, ury=1 on a 4×3 frame → exactly beats 10'h005 and 10'h006.
- **Decimation.** `cfg_drop_val_i`=2, 7 frames → frames 0, 3, 6 captured; no beats from the others; `busy_o` low during SKIP.
- **Back-pressure.** `ready_i`=0 for 3 samples → first sample held on `data_o`, 2 `overflow_o` pulses; the first beat is accepted when ready rises.
- **Disable mid-frame.** Deassert `cfg_en_i` after line 1 of a 3-line frame → all 3 lines still delivered; IDLE after the next vsync rise; no further beats.
- **Async reset.** Assert `rstn_i` mid-line → all outputs 0 immediately; after release with enable high, nothing is captured until the next vsync rise.
